exception_writer: RTL and testbench
===================================

EXCEPTION_WRITER -- requirements
Module: exception_writer

Interface
REQ-001 SHALL expose parameter EXC_VECTOR, default 32'hBFC00380, the exception handler entry address.
REQ-002 SHALL expose ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- exc_valid  in  1  MEM-stage exception request
- exc_code  in  5  ExcCode of the request
- exc_pc  in  32  PC of the faulting instruction
- exc_badvaddr  in  32  faulting address
- exc_bd  in  1  faulting instruction is in a delay slot
- eret_valid  in  1  ERET reached MEM
- instr_valid  in  1  MEM holds a real instruction
- hw_int  in  6  hardware interrupt lines
- Status_data  in  32  current CP0 Status
- cause_data  in  32  current CP0 Cause
- EPC_data  in  32  current CP0 EPC
- ready  out  1  FSM idle; able to accept a request
- we  out  32  CP0 write enables, one bit per register number
- Exception_code  out  5  value for Cause.ExcCode
- EXL  out  1  value for Status.EXL
- new_IE  out  1  value for Status.IE
- interrupt_enable  out  8  value for Status.IM
- hardware_interruption  out  6  value for Cause.IP[7:2]
- software_interruption  out  2  value for Cause.IP[1:0]
- EPCin  out  32  value for EPC
- BADADDR  out  32  value for BadVAddr
- Branch_delay  out  1  value for Cause.BD
- flush  out  1  squash IF through MEM
- redirect_valid  out  1  fetch PC override strobe
- redirect_pc  out  32  fetch PC override target
REQ-003 SHALL use one clock, clk; reset is rst, synchronous and active-high.

Function
REQ-004 SHALL implement FSM states IDLE, COMMIT and REDIRECT, with ready=1 only in IDLE.
REQ-005 SHALL define int_pending = instr_valid & Status_data[0] & ~Status_data[1] & |(hw_int & Status_data[15:10]).
REQ-006 In IDLE, the request sources SHALL have priority int_pending > exc_valid > eret_valid.
REQ-007 On an accepted request the FSM SHALL latch the request kind, code, PC, bad address and BD flag, then go to COMMIT on the next edge.
REQ-008 In IDLE with no request, the FSM SHALL stay in IDLE.
REQ-009 Requests arriving outside IDLE SHALL be ignored; the source holds the request until ready=1.
REQ-010 An interrupt SHALL use ExcCode 0 and the latched exc_pc.
REQ-011 COMMIT for an exception or interrupt SHALL last exactly one cycle and drive:
- we[12], we[13] and we[14] = 1
- we[8] = 1 only when the code is 4 or 5 (AdEL/AdES)
- Exception_code = latched code; EXL = 1
- EPCin = latched_bd ? pc-4 : pc, modulo 2^32
- Branch_delay = latched_bd; BADADDR = latched badvaddr
REQ-012 COMMIT for ERET SHALL drive we[12]=1 with EXL=0; all other we bits are 0.
REQ-013 In COMMIT, new_IE and interrupt_enable SHALL equal Status_data[0] and Status_data[15:8] (unchanged).
REQ-014 In COMMIT, hardware_interruption SHALL equal hw_int and software_interruption SHALL equal cause_data[9:8].
REQ-015 flush SHALL be 1 in both COMMIT and REDIRECT.
REQ-016 REDIRECT SHALL last one cycle with redirect_valid=1.
REQ-017 redirect_pc SHALL be EPC_data for ERET and EXC_VECTOR otherwise.
REQ-018 After REDIRECT the FSM SHALL return to IDLE.
REQ-019 Latency SHALL be fixed: request accepted at edge N, COMMIT in cycle N+1, REDIRECT in cycle N+2, ready=1 again in cycle N+3.
REQ-020 Outside COMMIT, we SHALL be 0 and the data outputs are don't-care; flush and redirect_valid SHALL be 0 outside the states named above.

Reset
REQ-021 On rst the FSM SHALL enter IDLE and every output SHALL be 0 except ready=1, including when rst is asserted mid-COMMIT or mid-REDIRECT.
REQ-022 A request present in the same cycle as rst SHALL be dropped.

Verification
REQ-023 Overflow: exc_valid=1, code=12, pc=0x80001000, bd=0 -> next cycle we=0x00007000, EPCin=0x80001000, EXL=1; the cycle after, redirect_pc=0xBFC00380.
REQ-024 Delay-slot AdEL: code=4, pc=0x80002004, bd=1, badvaddr=0x00000003 -> we=0x00007100, EPCin=0x80002000, BADADDR=0x00000003, Branch_delay=1.
REQ-025 Interrupt vs exception: Status=0x0000FF01, hw_int=6'b000001 and exc_valid asserted together -> Exception_code=0; the exception is ignored.
REQ-026 ERET: EPC_data=0x80003000 -> we=0x00001000 with EXL=0, then redirect_pc=0x80003000.
REQ-027 Masked interrupt: Status=0x00000003 (EXL=1), hw_int=6'h3F -> no request; ready remains 1.
REQ-028 Reset mid-COMMIT: rst pulsed in the COMMIT cycle -> the next cycle shows IDLE, we=0, flush=0, ready=1, and no redirect occurs.

Source files
------------

// File: rtl/exception_writer.sv
// Exception / interrupt / ERET sequencer for the MEM stage.
//
// Accepts one request in IDLE (interrupt > exception > ERET), spends one
// cycle in COMMIT driving the CP0 write enables and field values, then one
// cycle in REDIRECT steering fetch to the handler (or to EPC for ERET).
//
// Ports:
//   clk, rst           clock and synchronous active-high reset
//   exc_*              MEM-stage exception request (code, pc, badvaddr, bd)
//   eret_valid         ERET reached MEM
//   instr_valid        MEM holds a real instruction (gates interrupts)
//   hw_int             hardware interrupt lines
//   Status_data, cause_data, EPC_data   current CP0 contents
//   ready              idle, able to accept a request
//   we                 CP0 write enables, one bit per register number
//   Exception_code .. Branch_delay      CP0 field values, valid in COMMIT
//   flush              squash IF through MEM (COMMIT and REDIRECT)
//   redirect_valid/pc  fetch PC override (REDIRECT)
module exception_writer #(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC00380
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exc_valid,
  input  logic [4:0]  exc_code,
  input  logic [31:0] exc_pc,
  input  logic [31:0] exc_badvaddr,
  input  logic        exc_bd,
  input  logic        eret_valid,
  input  logic        instr_valid,
  input  logic [5:0]  hw_int,
  input  logic [31:0] Status_data,
  input  logic [31:0] cause_data,
  input  logic [31:0] EPC_data,
  output logic        ready,
  output logic [31:0] we,
  output logic [4:0]  Exception_code,
  output logic        EXL,
  output logic        new_IE,
  output logic [7:0]  interrupt_enable,
  output logic [5:0]  hardware_interruption,
  output logic [1:0]  software_interruption,
  output logic [31:0] EPCin,
  output logic [31:0] BADADDR,
  output logic        Branch_delay,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  typedef enum logic [1:0] {StIdle, StCommit, StRedirect} state_e;

  state_e      state_q, state_d;
  logic        is_eret_q, is_eret_d;
  logic [4:0]  code_q, code_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] badvaddr_q, badvaddr_d;
  logic        bd_q, bd_d;

  logic int_pending;

  // Interrupts need IE=1, EXL=0, an unmasked line and a real instruction to
  // attach EPC to.
  assign int_pending = instr_valid & Status_data[0] & ~Status_data[1] &
                       (|(hw_int & Status_data[15:10]));

  always_comb begin
    state_d    = state_q;
    is_eret_d  = is_eret_q;
    code_d     = code_q;
    pc_d       = pc_q;
    badvaddr_d = badvaddr_q;
    bd_d       = bd_q;
    unique case (state_q)
      StIdle: begin
        if (int_pending || exc_valid || eret_valid) begin
          state_d    = StCommit;
          pc_d       = exc_pc;
          badvaddr_d = exc_badvaddr;
          bd_d       = exc_bd;
          if (int_pending) begin
            is_eret_d = 1'b0;
            code_d    = 5'd0;
          end else if (exc_valid) begin
            is_eret_d = 1'b0;
            code_d    = exc_code;
          end else begin
            is_eret_d = 1'b1;
            code_d    = 5'd0;
          end
        end
      end
      StCommit:   state_d = StRedirect;
      StRedirect: state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      is_eret_q  <= 1'b0;
      code_q     <= 5'd0;
      pc_q       <= 32'd0;
      badvaddr_q <= 32'd0;
      bd_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      is_eret_q  <= is_eret_d;
      code_q     <= code_d;
      pc_q       <= pc_d;
      badvaddr_q <= badvaddr_d;
      bd_q       <= bd_d;
    end
  end

  always_comb begin
    ready                 = 1'b0;
    we                    = 32'd0;
    Exception_code        = 5'd0;
    EXL                   = 1'b0;
    new_IE                = 1'b0;
    interrupt_enable      = 8'd0;
    hardware_interruption = 6'd0;
    software_interruption = 2'd0;
    EPCin                 = 32'd0;
    BADADDR               = 32'd0;
    Branch_delay          = 1'b0;
    flush                 = 1'b0;
    redirect_valid        = 1'b0;
    redirect_pc           = 32'd0;
    unique case (state_q)
      StIdle: ready = 1'b1;
      StCommit: begin
        flush                 = 1'b1;
        new_IE                = Status_data[0];
        interrupt_enable      = Status_data[15:8];
        hardware_interruption = hw_int;
        software_interruption = cause_data[9:8];
        if (is_eret_q) begin
          we[12] = 1'b1;
          EXL    = 1'b0;
        end else begin
          we[12]         = 1'b1;
          we[13]         = 1'b1;
          we[14]         = 1'b1;
          // BadVAddr only for address-error codes (AdEL/AdES)
          we[8]          = (code_q == 5'd4) || (code_q == 5'd5);
          Exception_code = code_q;
          EXL            = 1'b1;
          EPCin          = bd_q ? (pc_q - 32'd4) : pc_q;
          BADADDR        = badvaddr_q;
          Branch_delay   = bd_q;
        end
      end
      StRedirect: begin
        flush          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = is_eret_q ? EPC_data : EXC_VECTOR;
      end
      default: ready = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_exception_writer.sv
// Directed self-checking bench for exception_writer.
module tb_exception_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic [31:0] exc_pc;
  logic [31:0] exc_badvaddr;
  logic        exc_bd;
  logic        eret_valid;
  logic        instr_valid;
  logic [5:0]  hw_int;
  logic [31:0] Status_data;
  logic [31:0] cause_data;
  logic [31:0] EPC_data;
  logic        ready;
  logic [31:0] we;
  logic [4:0]  Exception_code;
  logic        EXL;
  logic        new_IE;
  logic [7:0]  interrupt_enable;
  logic [5:0]  hardware_interruption;
  logic [1:0]  software_interruption;
  logic [31:0] EPCin;
  logic [31:0] BADADDR;
  logic        Branch_delay;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  exception_writer #(.EXC_VECTOR(32'hBFC00380)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .exc_valid             (exc_valid),
    .exc_code              (exc_code),
    .exc_pc                (exc_pc),
    .exc_badvaddr          (exc_badvaddr),
    .exc_bd                (exc_bd),
    .eret_valid            (eret_valid),
    .instr_valid           (instr_valid),
    .hw_int                (hw_int),
    .Status_data           (Status_data),
    .cause_data            (cause_data),
    .EPC_data              (EPC_data),
    .ready                 (ready),
    .we                    (we),
    .Exception_code        (Exception_code),
    .EXL                   (EXL),
    .new_IE                (new_IE),
    .interrupt_enable      (interrupt_enable),
    .hardware_interruption (hardware_interruption),
    .software_interruption (software_interruption),
    .EPCin                 (EPCin),
    .BADADDR               (BADADDR),
    .Branch_delay          (Branch_delay),
    .flush                 (flush),
    .redirect_valid        (redirect_valid),
    .redirect_pc           (redirect_pc)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, " ready"}, {31'd0, ready}, 32'd1);
    check({tag, " we"}, we, 32'd0);
    check({tag, " flush"}, {31'd0, flush}, 32'd0);
    check({tag, " redirect_valid"}, {31'd0, redirect_valid}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    exc_valid = 1'b1;  // present during reset; must be dropped
    exc_code = 5'd12; exc_pc = 32'h8000_1000; exc_badvaddr = 32'd0; exc_bd = 1'b0;
    eret_valid = 1'b0; instr_valid = 1'b1; hw_int = 6'd0;
    Status_data = 32'd0; cause_data = 32'd0; EPC_data = 32'd0;
    step();
    step();
    check("reset EXL", {31'd0, EXL}, 32'd0);
    check("reset EPCin", EPCin, 32'd0);
    check_idle("reset");
    rst = 1'b0;
    exc_valid = 1'b0;
    step();
    check_idle("post-reset no request");

    // Overflow
    exc_valid = 1'b1; exc_code = 5'd12; exc_pc = 32'h8000_1000; exc_bd = 1'b0;
    step();
    exc_valid = 1'b0;
    check("ov commit ready", {31'd0, ready}, 32'd0);
    check("ov commit we", we, 32'h0000_7000);
    check("ov commit EPCin", EPCin, 32'h8000_1000);
    check("ov commit EXL", {31'd0, EXL}, 32'd1);
    check("ov commit code", {27'd0, Exception_code}, 32'd12);
    check("ov commit flush", {31'd0, flush}, 32'd1);
    check("ov commit redirect_valid", {31'd0, redirect_valid}, 32'd0);
    step();
    check("ov redirect valid", {31'd0, redirect_valid}, 32'd1);
    check("ov redirect pc", redirect_pc, 32'hBFC0_0380);
    check("ov redirect flush", {31'd0, flush}, 32'd1);
    check("ov redirect we", we, 32'd0);
    check("ov redirect ready", {31'd0, ready}, 32'd0);
    step();
    check_idle("ov back to idle");

    // Delay-slot AdEL; interrupts masked off by instr_valid=0
    instr_valid = 1'b0; Status_data = 32'h0000_A501; hw_int = 6'h2A; cause_data = 32'h0000_0300;
    exc_valid = 1'b1; exc_code = 5'd4; exc_pc = 32'h8000_2004; exc_bd = 1'b1;
    exc_badvaddr = 32'h0000_0003;
    step();
    exc_valid = 1'b0;
    check("adel we", we, 32'h0000_7100);
    check("adel EPCin", EPCin, 32'h8000_2000);
    check("adel BADADDR", BADADDR, 32'h0000_0003);
    check("adel Branch_delay", {31'd0, Branch_delay}, 32'd1);
    check("adel code", {27'd0, Exception_code}, 32'd4);
    check("adel new_IE", {31'd0, new_IE}, 32'd1);
    check("adel interrupt_enable", {24'd0, interrupt_enable}, 32'h0000_00A5);
    check("adel hw", {26'd0, hardware_interruption}, 32'h0000_002A);
    check("adel sw", {30'd0, software_interruption}, 32'd3);
    step();
    check("adel redirect pc", redirect_pc, 32'hBFC0_0380);
    step();
    check_idle("adel idle");

    // Interrupt beats a simultaneous exception
    instr_valid = 1'b1; Status_data = 32'h0000_FF01; hw_int = 6'b000001; cause_data = 32'd0;
    exc_valid = 1'b1; exc_code = 5'd12; exc_pc = 32'h8000_4000; exc_bd = 1'b0;
    exc_badvaddr = 32'd0;
    step();
    exc_valid = 1'b0; hw_int = 6'd0;
    check("int code", {27'd0, Exception_code}, 32'd0);
    check("int we", we, 32'h0000_7000);
    check("int EPCin", EPCin, 32'h8000_4000);
    check("int EXL", {31'd0, EXL}, 32'd1);
    step();
    check("int redirect pc", redirect_pc, 32'hBFC0_0380);
    step();
    check_idle("int idle");

    // ERET
    Status_data = 32'd0; eret_valid = 1'b1; EPC_data = 32'h8000_3000;
    step();
    eret_valid = 1'b0;
    check("eret we", we, 32'h0000_1000);
    check("eret EXL", {31'd0, EXL}, 32'd0);
    check("eret flush", {31'd0, flush}, 32'd1);
    step();
    check("eret redirect valid", {31'd0, redirect_valid}, 32'd1);
    check("eret redirect pc", redirect_pc, 32'h8000_3000);
    step();
    check_idle("eret idle");

    // AdES beats a simultaneous ERET
    exc_valid = 1'b1; eret_valid = 1'b1; exc_code = 5'd5; exc_pc = 32'h8000_5008;
    exc_bd = 1'b0;
    step();
    exc_valid = 1'b0; eret_valid = 1'b0;
    check("ades we", we, 32'h0000_7100);
    check("ades EXL", {31'd0, EXL}, 32'd1);
    check("ades EPCin", EPCin, 32'h8000_5008);
    step();
    check("ades redirect pc", redirect_pc, 32'hBFC0_0380);
    step();
    check_idle("ades idle");

    // Masked interrupt: EXL=1 blocks it
    Status_data = 32'h0000_0003; hw_int = 6'h3F; instr_valid = 1'b1;
    step();
    check_idle("masked 1");
    step();
    check_idle("masked 2");
    hw_int = 6'd0; Status_data = 32'd0;

    // Reset pulsed during COMMIT
    exc_valid = 1'b1; exc_code = 5'd12; exc_pc = 32'h8000_6000;
    step();
    exc_valid = 1'b0;
    check("rst-mid commit we", we, 32'h0000_7000);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_idle("rst-mid after");
    check("rst-mid EXL", {31'd0, EXL}, 32'd0);
    step();
    check_idle("rst-mid no redirect");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
